// File: rtl/mac_transform_sequencer_pkg.sv
// Shared definitions for the MAC transform sequencer.
//   state_t : controller state encoding (3 bits)
//   LAT_W   : width of the read-latency down-counter
//   addr_w  : address width derived from log2 of the block side
package mac_transform_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int unsigned LAT_W = 4;

  function automatic int unsigned addr_w(input int unsigned log2_n);
    return 2 * log2_n;
  endfunction

endpackage

// File: rtl/mac_transform_sequencer_if.sv
// Handshake/bus bundle between the sequencer and its environment.
//   Inputs to sequencer : Start, Abort, Mode, X_In, Y_In, Out_Ready
//   Outputs             : Busy, Done, u, v, x, y, Read_Enable, Address,
//                         Clear_MAC, Active_MAC, Out_Valid, Out_Address
// master = job issuer / memory / result store side, slave = sequencer.
interface mac_transform_sequencer_if #(
  parameter int unsigned LOG2_N = 3
);
  import mac_transform_sequencer_pkg::*;

  localparam int unsigned ADDR_W = addr_w(LOG2_N);

  logic              Start;
  logic              Abort;
  logic              Mode;
  logic [LOG2_N-1:0] X_In;
  logic [LOG2_N-1:0] Y_In;
  logic              Out_Ready;

  logic              Busy;
  logic              Done;
  logic [LOG2_N-1:0] u;
  logic [LOG2_N-1:0] v;
  logic [LOG2_N-1:0] x;
  logic [LOG2_N-1:0] y;
  logic              Read_Enable;
  logic [ADDR_W-1:0] Address;
  logic              Clear_MAC;
  logic              Active_MAC;
  logic              Out_Valid;
  logic [ADDR_W-1:0] Out_Address;

  modport master (
    output Start, Abort, Mode, X_In, Y_In, Out_Ready,
    input  Busy, Done, u, v, x, y, Read_Enable, Address,
           Clear_MAC, Active_MAC, Out_Valid, Out_Address
  );

  modport slave (
    input  Start, Abort, Mode, X_In, Y_In, Out_Ready,
    output Busy, Done, u, v, x, y, Read_Enable, Address,
           Clear_MAC, Active_MAC, Out_Valid, Out_Address
  );

endinterface

// File: rtl/mac_transform_sequencer_index_counter_2d.sv
// Two-dimensional index counter (row, col), each LOG2_N bits.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   clear_i            : zero both indices (beats load/inc)
//   load_i             : load row_load_i / col_load_i (beats inc)
//   inc_i              : advance col; on col wrap advance row
//   row_o, col_o       : current indices
//   last_o             : both indices at N-1
module index_counter_2d #(
  parameter int unsigned LOG2_N = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [LOG2_N-1:0] row_load_i,
  input  logic [LOG2_N-1:0] col_load_i,
  input  logic              inc_i,
  output logic [LOG2_N-1:0] row_o,
  output logic [LOG2_N-1:0] col_o,
  output logic              last_o
);

  logic [LOG2_N-1:0] row_q;
  logic [LOG2_N-1:0] col_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (load_i) begin
      row_q <= row_load_i;
      col_q <= col_load_i;
    end else if (inc_i) begin
      if (col_q == '1) begin
        col_q <= '0;
        row_q <= row_q + LOG2_N'(1);
      end else begin
        col_q <= col_q + LOG2_N'(1);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == '1) && (col_q == '1);

endmodule

// File: rtl/mac_transform_sequencer.sv
// Controller for the MAC datapath of the block transform. For each output
// coordinate (x,y) it sweeps (u,v) over the NxN block: clear the MAC, then
// per element read memory, wait READ_LATENCY cycles and accumulate; finally
// present the result via Out_Valid/Out_Ready.
//   Clock, Reset : clock, synchronous active-high reset
//   bus          : slave side of mac_transform_sequencer_if
//                  (job control, coordinates, memory/MAC strobes, output)
module mac_transform_sequencer
  import mac_transform_sequencer_pkg::*;
#(
  parameter int unsigned LOG2_N       = 3,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  mac_transform_sequencer_if.slave    bus
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic              mode_q;
  logic [LAT_W-1:0]  lat_q;
  logic              busy_q, done_q, clr_q, rd_q, acc_q, ov_q;

  logic [LOG2_N-1:0] u_w, v_w, x_w, y_w;
  logic              uv_last, xy_last;
  logic              start_go, emit_hs, job_last;
  logic              uv_clear, uv_inc, xy_clear, xy_load, xy_inc;

  assign start_go = (state_q == IDLE) && bus.Start;
  assign emit_hs  = (state_q == EMIT) && bus.Out_Ready;
  assign job_last = mode_q || xy_last;

  // Abort rides on the counters' clear input, which outranks load/inc.
  assign uv_clear = bus.Abort || start_go || (emit_hs && !job_last);
  assign uv_inc   = (state_q == ACCUM) && !uv_last;
  assign xy_clear = bus.Abort || (start_go && !bus.Mode);
  assign xy_load  = start_go && bus.Mode;
  assign xy_inc   = emit_hs && !job_last;

  index_counter_2d #(.LOG2_N(LOG2_N)) u_uv_cnt (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .clear_i    (uv_clear),
    .load_i     (1'b0),
    .row_load_i ('0),
    .col_load_i ('0),
    .inc_i      (uv_inc),
    .row_o      (u_w),
    .col_o      (v_w),
    .last_o     (uv_last)
  );

  index_counter_2d #(.LOG2_N(LOG2_N)) u_xy_cnt (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .clear_i    (xy_clear),
    .load_i     (xy_load),
    .row_load_i (bus.X_In),
    .col_load_i (bus.Y_In),
    .inc_i      (xy_inc),
    .row_o      (x_w),
    .col_o      (y_w),
    .last_o     (xy_last)
  );

  always_comb begin
    state_d = state_q;
    if (bus.Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.Start) state_d = CLEAR;
        CLEAR:   state_d = READ;
        READ:    state_d = WAIT;
        WAIT:    if (lat_q == '0) state_d = ACCUM;
        ACCUM:   state_d = uv_last ? EMIT : READ;
        EMIT:    if (bus.Out_Ready) state_d = job_last ? DONE : CLEAR;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state, so each one is high
  // exactly while the state register holds the matching state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      rd_q    <= 1'b0;
      acc_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) mode_q <= bus.Mode;
      if (bus.Abort)               lat_q <= '0;
      else if (state_q == READ)    lat_q <= LAT_INIT;
      else if (state_q == WAIT && lat_q != '0) lat_q <= lat_q - LAT_W'(1);
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      clr_q  <= (state_d == CLEAR);
      rd_q   <= (state_d == READ);
      acc_q  <= (state_d == ACCUM);
      ov_q   <= (state_d == EMIT);
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Clear_MAC   = clr_q;
  assign bus.Read_Enable = rd_q;
  assign bus.Active_MAC  = acc_q;
  assign bus.Out_Valid   = ov_q;
  assign bus.u           = u_w;
  assign bus.v           = v_w;
  assign bus.x           = x_w;
  assign bus.y           = y_w;
  assign bus.Address     = {u_w, v_w};
  assign bus.Out_Address = {x_w, y_w};

endmodule
